icache_req_arbiter: RTL and testbench
=====================================

ICACHE_REQ_ARBITER -- requirements
Module: icache_req_arbiter

Interface
REQ-001 Parameter ADDR_W, default 40, virtual fetch address width.
REQ-002 Parameter CNT_W, default 16, kill-counter width.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 fetch_valid_i  input  1  demand fetch request.
REQ-006 fetch_vaddr_i  input  ADDR_W  demand fetch address.
REQ-007 fetch_ready_o  output  1  demand request accepted this cycle.
REQ-008 pf_valid_i  input  1  next-line prefetch request.
REQ-009 pf_vaddr_i  input  ADDR_W  prefetch address.
REQ-010 pf_ready_o  output  1  prefetch accepted this cycle.
REQ-011 flush_i  input  1  pipeline flush; kill any in-flight access.
REQ-012 icache_req_ready_i  input  1  icache can take a request.
REQ-013 icache_req_valid_o  output  1  request to icache.
REQ-014 icache_req_vaddr_o  output  ADDR_W  request address to icache.
REQ-015 icache_req_kill_o  output  1  kill of outstanding icache access.
REQ-016 icache_resp_valid_i  input  1  icache response.
REQ-017 icache_resp_xcpt_i  input  1  response carries instruction page fault.
REQ-018 fetch_resp_valid_o  output  1  response delivered to fetch.
REQ-019 fetch_resp_xcpt_o  output  1  page fault for delivered response.
REQ-020 pf_done_o  output  1  prefetch response retired (data discarded).
REQ-021 busy_o  output  1  state is not IDLE.
REQ-022 kill_cnt_o  output  CNT_W  count of killed accesses.

Function
REQ-023 FSM states IDLE, WAIT_RESP, KILL_WAIT; at most one outstanding icache access.
REQ-024 Grant in IDLE only, when icache_req_ready_i=1, flush_i=0, and a request is valid; fetch has fixed priority over prefetch.
REQ-025 icache_req_valid_o = IDLE & !flush_i & (fetch_valid_i | pf_valid_i), combinational; icache_req_vaddr_o = fetch_vaddr_i if fetch_valid_i else pf_vaddr_i.
REQ-026 fetch_ready_o = grant to fetch; pf_ready_o = grant to prefetch; never both; both 0 outside IDLE.
REQ-027 On grant: register owner (FETCH/PF), IDLE -> WAIT_RESP next cycle.
REQ-028 WAIT_RESP, icache_resp_valid_i=1, flush_i=0: owner FETCH -> fetch_resp_valid_o=1, fetch_resp_xcpt_o=icache_resp_xcpt_i same cycle; owner PF -> pf_done_o=1, xcpt ignored; -> IDLE.
REQ-029 No back-to-back issue: first new grant earliest one cycle after return to IDLE (response-to-request latency 1 cycle min).
REQ-030 WAIT_RESP, flush_i=1, no response: icache_req_kill_o=1 that cycle only, kill_cnt_o increments, -> KILL_WAIT.
REQ-031 WAIT_RESP, flush_i=1 and icache_resp_valid_i=1 same cycle: response discarded (no fetch_resp_valid_o, no pf_done_o), no kill, no count, -> IDLE.
REQ-032 KILL_WAIT: every response discarded; on icache_resp_valid_i -> IDLE; flush_i ignored.
REQ-033 flush_i in IDLE: no grant that cycle, no kill, no count.
REQ-034 kill_cnt_o saturates at all-ones; never wraps.
REQ-035 fetch_resp_valid_o, pf_done_o, icache_req_kill_o each asserted at most one cycle per access.
REQ-036 Response in IDLE (spurious): ignored, no output asserted.

Reset
REQ-037 rst_i=1 forces, asynchronously: state IDLE, owner FETCH, kill_cnt_o=0, busy_o=0.
REQ-038 During reset all outputs 0 (icache_req_vaddr_o, requests gated off); reset mid-access abandons it with no kill pulse.
REQ-039 First grant possible in first cycle after rst_i deasserts.

Verification
REQ-040 fetch_valid_i=1, vaddr 0x80001000, ready=1; response 3 cycles later xcpt=0 -> fetch_ready_o 1 cycle, fetch_resp_valid_o=1 xcpt=0 at response, busy_o 1 for 3 cycles.
REQ-041 fetch and pf valid same cycle (0x1000, 0x1010) -> icache_req_vaddr_o=0x1000, fetch_ready_o=1, pf_ready_o=0; pf granted one cycle after fetch response returns to IDLE.
REQ-042 PF outstanding, response xcpt=1 -> pf_done_o=1, fetch_resp_valid_o=0, fetch_resp_xcpt_o=0.
REQ-043 flush_i in WAIT_RESP, response 2 cycles later -> icache_req_kill_o 1 cycle, kill_cnt_o 0->1, no fetch_resp_valid_o, IDLE after response.
REQ-044 flush_i coincident with response -> no outputs, kill_cnt_o unchanged, IDLE next cycle.
REQ-045 CNT_W=2, five kill sequences -> kill_cnt_o 1,2,3,3,3.

Source files
------------

// File: rtl/icache_req_arbiter.sv
// Arbitrates demand fetch and next-line prefetch onto a single icache port.
// Only one access is outstanding; a flush kills it, and the icache response is then drained.
module icache_req_arbiter #(
  parameter int ADDR_W = 40,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fetch_valid_i,
  input  logic [ADDR_W-1:0] fetch_vaddr_i,
  output logic              fetch_ready_o,
  input  logic              pf_valid_i,
  input  logic [ADDR_W-1:0] pf_vaddr_i,
  output logic              pf_ready_o,
  input  logic              flush_i,
  input  logic              icache_req_ready_i,
  output logic              icache_req_valid_o,
  output logic [ADDR_W-1:0] icache_req_vaddr_o,
  output logic              icache_req_kill_o,
  input  logic              icache_resp_valid_i,
  input  logic              icache_resp_xcpt_i,
  output logic              fetch_resp_valid_o,
  output logic              fetch_resp_xcpt_o,
  output logic              pf_done_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  kill_cnt_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RESP = 2'd1,
    KILL_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_PF    = 1'b1
  } owner_t;

  state_t             state;
  state_t             state_nxt;
  owner_t             owner;
  owner_t             owner_nxt;
  logic [CNT_W-1:0]   kill_cnt;
  logic [CNT_W-1:0]   kill_cnt_nxt;

  logic in_idle;
  logic req_valid;
  logic grant_fetch;
  logic grant_pf;
  logic resp_ok;
  logic do_kill;

  // Request, grant and response qualifiers shared by next-state and output logic
  always_comb begin
    in_idle     = (state == IDLE);
    req_valid   = in_idle & ~flush_i & (fetch_valid_i | pf_valid_i);
    grant_fetch = req_valid & icache_req_ready_i & fetch_valid_i;
    grant_pf    = req_valid & icache_req_ready_i & ~fetch_valid_i;
    resp_ok     = (state == WAIT_RESP) & icache_resp_valid_i & ~flush_i;
    do_kill     = (state == WAIT_RESP) & flush_i & ~icache_resp_valid_i;
  end

  // State, owner and kill-counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      owner    <= OWN_FETCH;
      kill_cnt <= {CNT_W{1'b0}};
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      kill_cnt <= kill_cnt_nxt;
    end
  end

  // Next-state logic; a response coincident with a flush retires the access without a kill
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    kill_cnt_nxt = kill_cnt;
    case (state)
      IDLE: begin
        if (grant_fetch | grant_pf) begin
          state_nxt = WAIT_RESP;
          owner_nxt = grant_fetch ? OWN_FETCH : OWN_PF;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT_RESP: begin
        if (icache_resp_valid_i) begin
          state_nxt = IDLE;
        end else if (flush_i) begin
          state_nxt = KILL_WAIT;
        end else begin
          state_nxt = WAIT_RESP;
        end
      end
      KILL_WAIT: begin
        if (icache_resp_valid_i) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = KILL_WAIT;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Saturating count: holds at all-ones rather than wrapping
    if (do_kill && (kill_cnt != {CNT_W{1'b1}})) begin
      kill_cnt_nxt = kill_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      kill_cnt_nxt = kill_cnt;
    end
  end

  // Outputs; everything is forced low while reset is held
  always_comb begin
    if (rst_i) begin
      icache_req_valid_o = 1'b0;
      icache_req_vaddr_o = {ADDR_W{1'b0}};
      fetch_ready_o      = 1'b0;
      pf_ready_o         = 1'b0;
      icache_req_kill_o  = 1'b0;
      fetch_resp_valid_o = 1'b0;
      fetch_resp_xcpt_o  = 1'b0;
      pf_done_o          = 1'b0;
      busy_o             = 1'b0;
    end else begin
      icache_req_valid_o = req_valid;
      icache_req_vaddr_o = fetch_valid_i ? fetch_vaddr_i : pf_vaddr_i;
      fetch_ready_o      = grant_fetch;
      pf_ready_o         = grant_pf;
      icache_req_kill_o  = do_kill;
      fetch_resp_valid_o = resp_ok & (owner == OWN_FETCH);
      fetch_resp_xcpt_o  = resp_ok & (owner == OWN_FETCH) & icache_resp_xcpt_i;
      pf_done_o          = resp_ok & (owner == OWN_PF);
      busy_o             = ~in_idle;
    end
    kill_cnt_o = kill_cnt;
  end

endmodule

// File: tb/tb_icache_req_arbiter.sv
// Cycle-by-cycle scoreboard bench for icache_req_arbiter (CNT_W=2 to reach saturation quickly).
module tb_icache_req_arbiter;

  localparam int AW = 40;
  localparam int CW = 2;

  // expected-flag bit positions
  localparam logic [7:0] RV = 8'h80, FR = 8'h40, PR = 8'h20, KL = 8'h10;
  localparam logic [7:0] FV = 8'h08, FX = 8'h04, PD = 8'h02, BZ = 8'h01;
  localparam logic [AW-1:0] A0 = 40'h0080001000;
  localparam logic [AW-1:0] F1 = 40'h0000001000;
  localparam logic [AW-1:0] F2 = 40'h0000001010;
  localparam logic [AW-1:0] Z  = 40'h0;

  typedef struct packed {
    logic [7:0]    flags;
    logic [AW-1:0] ra;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_valid, pf_valid, flush, req_ready, resp_valid, resp_xcpt;
  logic [AW-1:0] fetch_vaddr, pf_vaddr;
  logic          fetch_ready, pf_ready, req_valid, req_kill;
  logic          fetch_resp_valid, fetch_resp_xcpt, pf_done, busy;
  logic [AW-1:0] req_vaddr;
  logic [CW-1:0] kill_cnt;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [CW-1:0] exp_cnt = 2'd0;

  icache_req_arbiter #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .fetch_valid_i(fetch_valid), .fetch_vaddr_i(fetch_vaddr), .fetch_ready_o(fetch_ready),
    .pf_valid_i(pf_valid), .pf_vaddr_i(pf_vaddr), .pf_ready_o(pf_ready),
    .flush_i(flush), .icache_req_ready_i(req_ready),
    .icache_req_valid_o(req_valid), .icache_req_vaddr_o(req_vaddr), .icache_req_kill_o(req_kill),
    .icache_resp_valid_i(resp_valid), .icache_resp_xcpt_i(resp_xcpt),
    .fetch_resp_valid_o(fetch_resp_valid), .fetch_resp_xcpt_o(fetch_resp_xcpt),
    .pf_done_o(pf_done), .busy_o(busy), .kill_cnt_o(kill_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // One clock cycle: drive inputs, push the expectation, compare at the falling edge.
  task automatic cyc(input logic r, input logic fv, input logic [AW-1:0] fa,
                     input logic pv, input logic [AW-1:0] pa, input logic fl,
                     input logic rdy, input logic rv, input logic rx, input logic [7:0] e);
    exp_t ex;
    exp_t got;
    rst = r; fetch_valid = fv; fetch_vaddr = fa; pf_valid = pv; pf_vaddr = pa;
    flush = fl; req_ready = rdy; resp_valid = rv; resp_xcpt = rx;
    ex.flags = r ? 8'h00 : e;
    ex.ra    = r ? Z : (fv ? fa : pa);
    ex.cnt   = r ? 2'd0 : exp_cnt;
    q.push_back(ex);
    @(negedge clk);
    if (q.size() == 0) begin
      check("queue_empty", 64'd1, 64'd0);
    end else begin
      got = q.pop_front();
      check("req_valid",  {63'd0, req_valid},        {63'd0, got.flags[7]});
      check("req_vaddr",  {24'd0, req_vaddr},        {24'd0, got.ra});
      check("fetch_rdy",  {63'd0, fetch_ready},      {63'd0, got.flags[6]});
      check("pf_rdy",     {63'd0, pf_ready},         {63'd0, got.flags[5]});
      check("kill",       {63'd0, req_kill},         {63'd0, got.flags[4]});
      check("fresp_vld",  {63'd0, fetch_resp_valid}, {63'd0, got.flags[3]});
      check("fresp_xcpt", {63'd0, fetch_resp_xcpt},  {63'd0, got.flags[2]});
      check("pf_done",    {63'd0, pf_done},          {63'd0, got.flags[1]});
      check("busy",       {63'd0, busy},             {63'd0, got.flags[0]});
      check("kill_cnt",   {62'd0, kill_cnt},         {62'd0, got.cnt});
    end
    @(posedge clk);
    #1;
    if (r) begin
      exp_cnt = 2'd0;
    end else if (e[4] && (exp_cnt != 2'd3)) begin
      exp_cnt = exp_cnt + 2'd1;
    end
  endtask

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; pf_valid = 1'b0; flush = 1'b0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_xcpt = 1'b0; fetch_vaddr = Z; pf_vaddr = Z;
    @(posedge clk);
    #1;
    // reset held with active inputs: every output low
    cyc(1'b1, 1'b1, A0, 1'b1, F2, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    // single demand fetch, response three cycles after grant
    cyc(1'b0, 1'b1, A0, 1'b0, Z, 1'b0, 1'b1, 1'b0, 1'b0, RV | FR);
    cyc(1'b0, 1'b0, Z,  1'b0, Z, 1'b0, 1'b1, 1'b0, 1'b0, BZ);
    cyc(1'b0, 1'b0, Z,  1'b0, Z, 1'b0, 1'b1, 1'b0, 1'b0, BZ);
    cyc(1'b0, 1'b0, Z,  1'b0, Z, 1'b0, 1'b1, 1'b1, 1'b0, FV | BZ);
    cyc(1'b0, 1'b0, Z,  1'b0, Z, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    // fetch beats prefetch; prefetch granted after fetch completes
    cyc(1'b0, 1'b1, F1, 1'b1, F2, 1'b0, 1'b1, 1'b0, 1'b0, RV | FR);
    cyc(1'b0, 1'b0, Z,  1'b1, F2, 1'b0, 1'b1, 1'b0, 1'b0, BZ);
    cyc(1'b0, 1'b0, Z,  1'b1, F2, 1'b0, 1'b1, 1'b1, 1'b0, FV | BZ);
    cyc(1'b0, 1'b0, Z,  1'b1, F2, 1'b0, 1'b1, 1'b0, 1'b0, RV | PR);
    // prefetch response with page fault: retired silently
    cyc(1'b0, 1'b0, Z,  1'b0, Z,  1'b0, 1'b1, 1'b1, 1'b1, PD | BZ);
    // icache not ready: request visible, no grant
    cyc(1'b0, 1'b1, A0, 1'b0, Z,  1'b0, 1'b0, 1'b0, 1'b0, RV);
    // flush in IDLE blocks grant
    cyc(1'b0, 1'b1, A0, 1'b0, Z,  1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    // spurious response in IDLE
    cyc(1'b0, 1'b0, Z,  1'b0, Z,  1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    // demand fetch with page fault delivered
    cyc(1'b0, 1'b1, A0, 1'b0, Z,  1'b0, 1'b1, 1'b0, 1'b0, RV | FR);
    cyc(1'b0, 1'b0, Z,  1'b0, Z,  1'b0, 1'b1, 1'b1, 1'b1, FV | FX | BZ);
    // flush while waiting: one kill pulse, count 0->1, response drained
    cyc(1'b0, 1'b1, A0, 1'b0, Z,  1'b0, 1'b1, 1'b0, 1'b0, RV | FR);
    cyc(1'b0, 1'b0, Z,  1'b0, Z,  1'b1, 1'b1, 1'b0, 1'b0, KL | BZ);
    cyc(1'b0, 1'b0, Z,  1'b0, Z,  1'b1, 1'b1, 1'b0, 1'b0, BZ);
    cyc(1'b0, 1'b0, Z,  1'b0, Z,  1'b0, 1'b1, 1'b1, 1'b0, BZ);
    cyc(1'b0, 1'b0, Z,  1'b0, Z,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    // flush coincident with response: nothing out, no kill, IDLE next cycle
    cyc(1'b0, 1'b1, A0, 1'b0, Z,  1'b0, 1'b1, 1'b0, 1'b0, RV | FR);
    cyc(1'b0, 1'b0, Z,  1'b0, Z,  1'b1, 1'b1, 1'b1, 1'b0, BZ);
    cyc(1'b0, 1'b1, A0, 1'b0, Z,  1'b0, 1'b1, 1'b0, 1'b0, RV | FR);
    cyc(1'b0, 1'b0, Z,  1'b0, Z,  1'b0, 1'b1, 1'b1, 1'b0, FV | BZ);
    // four more kills (fetch and prefetch owners): count 2,3,3,3
    for (int i = 0; i < 4; i++) begin
      if (i[0]) cyc(1'b0, 1'b1, A0, 1'b0, Z,  1'b0, 1'b1, 1'b0, 1'b0, RV | FR);
      else      cyc(1'b0, 1'b0, Z,  1'b1, F2, 1'b0, 1'b1, 1'b0, 1'b0, RV | PR);
      cyc(1'b0, 1'b0, Z, 1'b0, Z, 1'b1, 1'b1, 1'b0, 1'b0, KL | BZ);
      cyc(1'b0, 1'b0, Z, 1'b0, Z, 1'b0, 1'b1, 1'b1, 1'b1, BZ);
    end
    cyc(1'b0, 1'b0, Z,  1'b0, Z,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    // reset mid-access with flush: no kill, counter cleared, fresh grant afterwards
    cyc(1'b0, 1'b1, A0, 1'b0, Z,  1'b0, 1'b1, 1'b0, 1'b0, RV | FR);
    cyc(1'b0, 1'b0, Z,  1'b0, Z,  1'b0, 1'b1, 1'b0, 1'b0, BZ);
    cyc(1'b1, 1'b0, Z,  1'b0, Z,  1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, Z,  1'b1, F2, 1'b0, 1'b1, 1'b0, 1'b0, RV | PR);
    cyc(1'b0, 1'b0, Z,  1'b0, Z,  1'b0, 1'b1, 1'b1, 1'b0, PD | BZ);
    cyc(1'b0, 1'b0, Z,  1'b0, Z,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
